// File: rtl/vga_scanout.sv
`default_nettype none
// ============================================================================
// Module      : vga_scanout
// Description : VGA timing generator and pixel scanout. Walks a raster of
//               H_TOTAL x V_TOTAL positions at the pixel-enable rate, pulls
//               RGB565 pixels from a framebuffer stream during the active
//               window, and produces registered RGB/sync/DE outputs with
//               sticky underflow reporting.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_scanout #(
    parameter int   H_ACTIVE = 800,
    parameter int   H_FP     = 40,
    parameter int   H_SYNC   = 128,
    parameter int   H_BP     = 88,
    parameter int   V_ACTIVE = 600,
    parameter int   V_FP     = 1,
    parameter int   V_SYNC   = 4,
    parameter int   V_BP     = 23,
    parameter logic SYNC_POL = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        pix_ce_i,
    input  logic        enable_i,
    input  logic        pix_valid_i,
    input  logic [15:0] pix_data_i,
    output logic        pix_ready_o,
    output logic [9:0]  req_x_o,
    output logic [9:0]  req_y_o,
    output logic [15:0] rgb_o,
    output logic        hsync_o,
    output logic        vsync_o,
    output logic        de_o,
    output logic        frame_start_o,
    input  logic        clr_underflow_i,
    output logic        underflow_o,
    output logic [15:0] underflow_cnt_o,
    output logic        busy_o
);

    // ------------------------------------------------------------------------
    // Raster geometry, all pre-computed as 11-bit constants so every compare
    // below is counter-vs-constant.
    // ------------------------------------------------------------------------
    localparam logic [10:0] H_ACT_END    = 11'(H_ACTIVE);
    localparam logic [10:0] H_SYNC_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_SYNC_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] H_LAST       = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);

    localparam logic [10:0] V_ACT_END    = 11'(V_ACTIVE);
    localparam logic [10:0] V_ACT_LAST   = 11'(V_ACTIVE - 1);
    localparam logic [10:0] V_SYNC_START = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] V_SYNC_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [10:0] V_LAST       = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

    localparam logic [15:0] CNT_MAX      = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [10:0] h_cnt;
    logic [10:0] v_cnt;

    logic        scanning;
    logic        h_end;
    logic        v_end;
    logic        active;
    logic        hsync_on;
    logic        vsync_on;
    logic        consume;
    logic        underflow_evt;
    logic        at_origin;

    // ------------------------------------------------------------------------
    // Position decode
    // ------------------------------------------------------------------------
    assign scanning      = (state != ST_IDLE);
    assign h_end         = (h_cnt == H_LAST);
    assign v_end         = (v_cnt == V_LAST);
    assign active        = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
    assign hsync_on      = (h_cnt >= H_SYNC_START) && (h_cnt < H_SYNC_END);
    assign vsync_on      = (v_cnt >= V_SYNC_START) && (v_cnt < V_SYNC_END);
    assign at_origin     = (h_cnt == 11'd0) && (v_cnt == 11'd0);

    // Handshake toward the framebuffer: a slot is offered only while scanning
    // the active window on a pixel-enable cycle.
    assign pix_ready_o   = pix_ce_i && scanning && active;
    assign consume       = pix_ready_o && pix_valid_i;
    assign underflow_evt = pix_ready_o && !pix_valid_i;

    assign busy_o        = scanning;
    assign req_x_o       = active ? 10'(h_cnt) : 10'd0;

    // ------------------------------------------------------------------------
    // Control FSM. All transitions are qualified by the pixel enable so that
    // busy_o moves in step with the raster.
    // ------------------------------------------------------------------------

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode: STOP keeps scanning until the last raster position,
    // and re-enabling from STOP resumes RUN with no break in timing.
    always_comb begin
        state_next = state;
        if (pix_ce_i) begin
            case (state)
                ST_IDLE: begin
                    if (enable_i) begin
                        state_next = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!enable_i) begin
                        state_next = ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (enable_i) begin
                        state_next = ST_RUN;
                    end else if (h_end && v_end) begin
                        state_next = ST_IDLE;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    // Raster counters: held at the origin while idle, otherwise advance one
    // position per pixel enable with line and frame wrap.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            h_cnt <= 11'd0;
            v_cnt <= 11'd0;
        end else if (pix_ce_i) begin
            if (!scanning) begin
                h_cnt <= 11'd0;
                v_cnt <= 11'd0;
            end else if (h_end) begin
                h_cnt <= 11'd0;
                v_cnt <= v_end ? 11'd0 : (v_cnt + 11'd1);
            end else begin
                h_cnt <= h_cnt + 11'd1;
            end
        end
    end

    // Video output stage: one pixel-enable of latency, every output sampled
    // from the same raster position. Underflow slots show black with DE high.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rgb_o   <= 16'd0;
            de_o    <= 1'b0;
            hsync_o <= ~SYNC_POL;
            vsync_o <= ~SYNC_POL;
        end else if (pix_ce_i) begin
            if (!scanning) begin
                rgb_o   <= 16'd0;
                de_o    <= 1'b0;
                hsync_o <= ~SYNC_POL;
                vsync_o <= ~SYNC_POL;
            end else begin
                rgb_o   <= consume ? pix_data_i : 16'd0;
                de_o    <= active;
                hsync_o <= hsync_on ? SYNC_POL : ~SYNC_POL;
                vsync_o <= vsync_on ? SYNC_POL : ~SYNC_POL;
            end
        end
    end

    // Frame origin marker: a single-clk pulse, cleared on the very next clk
    // even when pixel enables are sparse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            frame_start_o <= 1'b0;
        end else begin
            frame_start_o <= pix_ce_i && (state == ST_RUN) && at_origin;
        end
    end

    // Prefetch line index: updated as the beam leaves the active part of a
    // line, pointing at the next line to fetch (wrapping to 0 after the last
    // visible line and throughout vertical blanking).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            req_y_o <= 10'd0;
        end else if (pix_ce_i && scanning && (h_cnt == H_ACT_END)) begin
            req_y_o <= (v_cnt < V_ACT_LAST) ? 10'(v_cnt + 11'd1) : 10'd0;
        end
    end

    // Underflow status: a clear coinciding with a new underflow leaves the
    // flag set and the count at one, so that event is never lost.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            underflow_o     <= 1'b0;
            underflow_cnt_o <= 16'd0;
        end else if (clr_underflow_i) begin
            underflow_o     <= underflow_evt;
            underflow_cnt_o <= underflow_evt ? 16'd1 : 16'd0;
        end else if (underflow_evt) begin
            underflow_o <= 1'b1;
            if (underflow_cnt_o != CNT_MAX) begin
                underflow_cnt_o <= underflow_cnt_o + 16'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_scanout.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_scanout
// Description : Self-checking bench for vga_scanout on a reduced raster,
//               compared against a position-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_scanout;

    localparam int   HA  = 16;
    localparam int   HF  = 3;
    localparam int   HS  = 5;
    localparam int   HB  = 4;
    localparam int   VA  = 10;
    localparam int   VF  = 1;
    localparam int   VS  = 2;
    localparam int   VB  = 3;
    localparam logic POL = 1'b1;
    localparam int   HT  = HA + HF + HS + HB;
    localparam int   VT  = VA + VF + VS + VB;
    localparam int   FR  = HT * VT;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        pix_ce_i = 1'b0;
    logic        enable_i = 1'b0;
    logic        pix_valid_i = 1'b0;
    logic [15:0] pix_data_i = 16'd0;
    logic        clr_underflow_i = 1'b0;
    logic        pix_ready_o;
    logic [9:0]  req_x_o;
    logic [9:0]  req_y_o;
    logic [15:0] rgb_o;
    logic        hsync_o;
    logic        vsync_o;
    logic        de_o;
    logic        frame_start_o;
    logic        underflow_o;
    logic [15:0] underflow_cnt_o;
    logic        busy_o;

    int total = 0;
    int bad   = 0;

    // Reference model: mode 0 idle, 1 run, 2 stop; raster position as a
    // linear index into the frame.
    int          m_mode;
    int          m_pos;
    logic [15:0] e_rgb;
    logic        e_de, e_hs, e_vs, e_fs, e_uf;
    logic [15:0] e_cnt;
    logic [9:0]  e_reqy;
    logic        e_ready;
    logic [9:0]  e_reqx;

    vga_scanout #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(POL)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .pix_ce_i        (pix_ce_i),
        .enable_i        (enable_i),
        .pix_valid_i     (pix_valid_i),
        .pix_data_i      (pix_data_i),
        .pix_ready_o     (pix_ready_o),
        .req_x_o         (req_x_o),
        .req_y_o         (req_y_o),
        .rgb_o           (rgb_o),
        .hsync_o         (hsync_o),
        .vsync_o         (vsync_o),
        .de_o            (de_o),
        .frame_start_o   (frame_start_o),
        .clr_underflow_i (clr_underflow_i),
        .underflow_o     (underflow_o),
        .underflow_cnt_o (underflow_cnt_o),
        .busy_o          (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic m_reset();
        m_mode = 0; m_pos = 0;
        e_rgb = 16'd0; e_de = 1'b0; e_hs = ~POL; e_vs = ~POL; e_fs = 1'b0;
        e_uf = 1'b0; e_cnt = 16'd0; e_reqy = 10'd0;
    endtask

    // Combinational expectations for the current inputs and position.
    task automatic m_comb();
        int h, v;
        logic act;
        h = m_pos % HT;
        v = m_pos / HT;
        act = (h < HA) && (v < VA);
        e_ready = pix_ce_i && (m_mode != 0) && act;
        e_reqx  = act ? 10'(h) : 10'd0;
    endtask

    // Clock-edge update of the model.
    task automatic m_seq();
        int h, v;
        logic act, rdy, uf_ev, last;
        h = m_pos % HT;
        v = m_pos / HT;
        act = (h < HA) && (v < VA);
        rdy = pix_ce_i && (m_mode != 0) && act;
        uf_ev = rdy && !pix_valid_i;
        last = (m_pos == FR - 1);
        e_fs = 1'b0;
        if (pix_ce_i) begin
            if (m_mode == 0) begin
                e_rgb = 16'd0; e_de = 1'b0; e_hs = ~POL; e_vs = ~POL;
            end else begin
                e_de  = act;
                e_rgb = (rdy && pix_valid_i) ? pix_data_i : 16'd0;
                e_hs  = (h >= HA + HF && h < HA + HF + HS) ? POL : ~POL;
                e_vs  = (v >= VA + VF && v < VA + VF + VS) ? POL : ~POL;
                if (h == HA) e_reqy = (v < VA - 1) ? 10'(v + 1) : 10'd0;
                e_fs  = (m_mode == 1) && (m_pos == 0);
            end
            m_pos = (m_mode == 0) ? 0 : (m_pos + 1) % FR;
            case (m_mode)
                0:       m_mode = enable_i ? 1 : 0;
                1:       m_mode = enable_i ? 1 : 2;
                default: m_mode = enable_i ? 1 : (last ? 0 : 2);
            endcase
        end
        if (clr_underflow_i) begin
            e_uf = uf_ev;
            e_cnt = uf_ev ? 16'd1 : 16'd0;
        end else if (uf_ev) begin
            e_uf = 1'b1;
            if (e_cnt != 16'hFFFF) e_cnt = e_cnt + 16'd1;
        end
    endtask

    function automatic logic [47:0] got_regs();
        return {rgb_o, de_o, hsync_o, vsync_o, frame_start_o, req_y_o,
                underflow_o, underflow_cnt_o, busy_o};
    endfunction

    function automatic logic [47:0] exp_regs();
        return {e_rgb, e_de, e_hs, e_vs, e_fs, e_reqy, e_uf, e_cnt, (m_mode != 0)};
    endfunction

    task automatic apply(input logic ce, input logic en, input logic valid,
                         input logic [15:0] data, input logic clr);
        @(negedge clk_i);
        pix_ce_i = ce; enable_i = en; pix_valid_i = valid;
        pix_data_i = data; clr_underflow_i = clr;
        #1;
        m_comb();
    endtask

    task automatic tick();
        @(posedge clk_i);
        m_seq();
        #1;
    endtask

    task automatic test_reset();
        pix_ce_i = 1'b1; enable_i = 1'b1; pix_valid_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        total++;
        if ({pix_ready_o, busy_o, req_x_o} !== 12'd0) begin
            bad++; $display("FAIL reset_comb: got ready/busy/x=%h expected 0", {pix_ready_o, busy_o, req_x_o});
        end
        total++;
        if ({rgb_o, de_o, frame_start_o} !== 18'd0) begin
            bad++; $display("FAIL reset_video: got rgb/de/fs=%h expected 0", {rgb_o, de_o, frame_start_o});
        end
        total++;
        if ({hsync_o, vsync_o} !== {~POL, ~POL}) begin
            bad++; $display("FAIL reset_sync: got %b expected %b", {hsync_o, vsync_o}, {~POL, ~POL});
        end
        total++;
        if ({req_y_o, underflow_o, underflow_cnt_o} !== 27'd0) begin
            bad++; $display("FAIL reset_status: got y/uf/cnt=%h expected 0", {req_y_o, underflow_o, underflow_cnt_o});
        end
        m_reset();
        @(negedge clk_i);
        rst_ni = 1'b1;
        pix_ce_i = 1'b0; enable_i = 1'b0;
    endtask

    task automatic test_free_run();
        int de_n = 0, hs_n = 0, vs_n = 0, fs_n = 0;
        for (int i = 0; i < 2 * FR + 10; i++) begin
            apply(1'b1, 1'b1, 1'b1, 16'($urandom), 1'b0);
            total++;
            if ({pix_ready_o, req_x_o} !== {e_ready, e_reqx}) begin
                bad++; $display("FAIL free_run_comb: got %h expected %h", {pix_ready_o, req_x_o}, {e_ready, e_reqx});
            end
            tick();
            total++;
            if (got_regs() !== exp_regs()) begin
                bad++; $display("FAIL free_run_regs: got %h expected %h", got_regs(), exp_regs());
            end
            if (i >= 5 && i < 5 + FR) begin
                de_n += int'(de_o); hs_n += int'(hsync_o == POL);
                vs_n += int'(vsync_o == POL); fs_n += int'(frame_start_o);
            end
        end
        total++;
        if (de_n != HA * VA) begin
            bad++; $display("FAIL de_per_frame: got %0d expected %0d", de_n, HA * VA);
        end
        total++;
        if (hs_n != HS * VT) begin
            bad++; $display("FAIL hsync_per_frame: got %0d expected %0d", hs_n, HS * VT);
        end
        total++;
        if (vs_n != VS * HT) begin
            bad++; $display("FAIL vsync_per_frame: got %0d expected %0d", vs_n, VS * HT);
        end
        total++;
        if (fs_n != 1) begin
            bad++; $display("FAIL frame_start_per_frame: got %0d expected 1", fs_n);
        end
    endtask

    task automatic test_underflow();
        logic found = 1'b0;
        for (int i = 0; i < 2 * FR && !found; i++) begin
            apply(1'b1, 1'b1, 1'b1, 16'($urandom), 1'b0);
            if ((m_pos % HT) >= 1 && (m_pos % HT) <= HA - 7 && (m_pos / HT) < VA) found = 1'b1;
            tick();
        end
        total++;
        if (!found) begin
            bad++; $display("FAIL underflow_setup: got no active slot expected one");
        end
        for (int k = 0; k < 3; k++) begin
            apply(1'b1, 1'b1, 1'b0, 16'($urandom), 1'b0);
            total++;
            if (pix_ready_o !== 1'b1) begin
                bad++; $display("FAIL underflow_ready: got %b expected 1", pix_ready_o);
            end
            tick();
            total++;
            if ({rgb_o, de_o} !== 17'h1) begin
                bad++; $display("FAIL underflow_slot: got rgb/de=%h expected 00001", {rgb_o, de_o});
            end
        end
        total++;
        if ({underflow_o, underflow_cnt_o} !== {1'b1, 16'd3}) begin
            bad++; $display("FAIL underflow_count: got uf=%b cnt=%0d expected uf=1 cnt=3", underflow_o, underflow_cnt_o);
        end
        apply(1'b1, 1'b1, 1'b1, 16'($urandom), 1'b1);
        tick();
        total++;
        if ({underflow_o, underflow_cnt_o} !== 17'd0) begin
            bad++; $display("FAIL underflow_clear: got uf=%b cnt=%0d expected 0 0", underflow_o, underflow_cnt_o);
        end
        apply(1'b1, 1'b1, 1'b0, 16'($urandom), 1'b1);
        tick();
        total++;
        if ({underflow_o, underflow_cnt_o} !== {1'b1, 16'd1}) begin
            bad++; $display("FAIL underflow_clear_collide: got uf=%b cnt=%0d expected 1 1", underflow_o, underflow_cnt_o);
        end
        apply(1'b1, 1'b1, 1'b1, 16'($urandom), 1'b1);
        tick();
        total++;
        if (got_regs() !== exp_regs()) begin
            bad++; $display("FAIL underflow_regs: got %h expected %h", got_regs(), exp_regs());
        end
    endtask

    task automatic test_req_y();
        int targets[2] = '{5 * HT + HA, (VA - 1) * HT + HA};
        logic [9:0] want[2] = '{10'd6, 10'd0};
        for (int t = 0; t < 2; t++) begin
            logic hit = 1'b0;
            for (int i = 0; i < 2 * FR && !hit; i++) begin
                apply(1'b1, 1'b1, 1'b1, 16'($urandom), 1'b0);
                if (m_pos == targets[t]) hit = 1'b1;
                tick();
            end
            total++;
            if (!hit || req_y_o !== want[t]) begin
                bad++; $display("FAIL req_y_%0d: got %0d (reached=%b) expected %0d", t, req_y_o, hit, want[t]);
            end
        end
    endtask

    task automatic test_stop();
        int n = 0;
        logic hit = 1'b0;
        for (int i = 0; i < 2 * FR && !hit; i++) begin
            apply(1'b1, 1'b1, 1'b1, 16'($urandom), 1'b0);
            if (m_pos == 3 * HT) hit = 1'b1;
            else tick();
        end
        for (int i = 0; i < 2 * FR; i++) begin
            if (i > 0) apply(1'b1, 1'b0, 1'b1, 16'($urandom), 1'b0);
            else begin enable_i = 1'b0; #1; m_comb(); end
            total++;
            if ({pix_ready_o, req_x_o} !== {e_ready, e_reqx}) begin
                bad++; $display("FAIL stop_comb: got %h expected %h", {pix_ready_o, req_x_o}, {e_ready, e_reqx});
            end
            tick();
            n++;
            total++;
            if (got_regs() !== exp_regs()) begin
                bad++; $display("FAIL stop_regs: got %h expected %h", got_regs(), exp_regs());
            end
            if (busy_o === 1'b0) break;
        end
        total++;
        if (n != FR - 3 * HT) begin
            bad++; $display("FAIL stop_length: got %0d ce expected %0d", n, FR - 3 * HT);
        end
        apply(1'b1, 1'b0, 1'b1, 16'($urandom), 1'b0);
        total++;
        if ({pix_ready_o, busy_o} !== 2'b00) begin
            bad++; $display("FAIL stop_idle: got ready/busy=%b expected 00", {pix_ready_o, busy_o});
        end
        tick();
        n = 0;
        for (int i = 0; i < 10; i++) begin
            apply(1'b1, 1'b1, 1'b1, 16'($urandom), 1'b0);
            tick();
            n++;
            if (frame_start_o === 1'b1) break;
        end
        total++;
        if (n != 2) begin
            bad++; $display("FAIL restart_frame_start: got pulse after %0d ce expected 2", n);
        end
    endtask

    task automatic test_gated_ce();
        int fs_n = 0;
        logic prev_fs = 1'b0;
        for (int i = 0; i < 2 * FR; i++) begin
            apply(1'(i % 2), 1'b1, 1'b1, 16'($urandom), 1'b0);
            total++;
            if ({pix_ready_o, req_x_o} !== {e_ready, e_reqx}) begin
                bad++; $display("FAIL gated_comb: got %h expected %h", {pix_ready_o, req_x_o}, {e_ready, e_reqx});
            end
            tick();
            total++;
            if (got_regs() !== exp_regs()) begin
                bad++; $display("FAIL gated_regs: got %h expected %h", got_regs(), exp_regs());
            end
            total++;
            if (prev_fs && frame_start_o) begin
                bad++; $display("FAIL gated_fs_width: got 2 clk pulse expected 1 clk");
            end
            prev_fs = frame_start_o;
            fs_n += int'(frame_start_o);
        end
        total++;
        if (fs_n != 1) begin
            bad++; $display("FAIL gated_fs_count: got %0d expected 1", fs_n);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            apply($urandom_range(0, 9) < 7, $urandom_range(0, 99) < 97,
                  $urandom_range(0, 99) < 85, 16'($urandom), $urandom_range(0, 99) < 3);
            total++;
            if ({pix_ready_o, req_x_o} !== {e_ready, e_reqx}) begin
                bad++; $display("FAIL random_comb: got %h expected %h", {pix_ready_o, req_x_o}, {e_ready, e_reqx});
            end
            tick();
            total++;
            if (got_regs() !== exp_regs()) begin
                bad++; $display("FAIL random_regs: got %h expected %h", got_regs(), exp_regs());
            end
        end
    endtask

    task automatic test_reset_mid();
        logic hit = 1'b0;
        for (int i = 0; i < 3 * FR && !hit; i++) begin
            apply(1'b1, 1'b1, !(m_pos == 2 * HT + 1), 16'($urandom), 1'b0);
            tick();
            if (m_pos == 3 * HT + 5 && m_mode == 1) hit = 1'b1;
        end
        total++;
        if (!hit || underflow_o !== 1'b1) begin
            bad++; $display("FAIL reset_mid_setup: got reached=%b uf=%b expected 1 1", hit, underflow_o);
        end
        #2;
        rst_ni = 1'b0;
        #1;
        total++;
        if ({pix_ready_o, busy_o, req_x_o, req_y_o} !== 22'd0) begin
            bad++; $display("FAIL reset_mid_ctrl: got %h expected 0", {pix_ready_o, busy_o, req_x_o, req_y_o});
        end
        total++;
        if ({rgb_o, de_o, frame_start_o, underflow_o, underflow_cnt_o} !== 35'd0) begin
            bad++; $display("FAIL reset_mid_out: got %h expected 0", {rgb_o, de_o, frame_start_o, underflow_o, underflow_cnt_o});
        end
        total++;
        if ({hsync_o, vsync_o} !== {~POL, ~POL}) begin
            bad++; $display("FAIL reset_mid_sync: got %b expected %b", {hsync_o, vsync_o}, {~POL, ~POL});
        end
        m_reset();
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    initial begin
        m_reset();
        test_reset();
        test_free_run();
        test_underflow();
        test_req_y();
        test_stop();
        test_gated_ce();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_scanout.md
VGA_SCANOUT -- requirements
Module: vga_scanout

Interface
REQ-001 Parameters (name, default, meaning); the block SHALL provide:
- H_ACTIVE, 800, visible pixels per line
- H_FP, 40, horizontal front porch
- H_SYNC, 128, hsync width
- H_BP, 88, horizontal back porch
- V_ACTIVE, 600, visible lines
- V_FP, 1, vertical front porch
- V_SYNC, 4, vsync width
- V_BP, 23, vertical back porch
- SYNC_POL, 1, sync asserted level
REQ-002 Ports (name, direction, width, meaning); the block SHALL provide:
- clk_i, in, 1, clock
- rst_ni, in, 1, reset: asynchronous, active-low
- pix_ce_i, in, 1, pixel-rate enable strobe
- enable_i, in, 1, request scanout
- pix_valid_i, in, 1, pixel stream valid (framebuffer output)
- pix_data_i, in, 16, RGB565 pixel
- pix_ready_o, out, 1, pixel consumed this cycle
- req_x_o, out, 10, current active column
- req_y_o, out, 10, line to prefetch
- rgb_o, out, 16, displayed pixel
- hsync_o, out, 1, horizontal sync
- vsync_o, out, 1, vertical sync
- de_o, out, 1, data enable
- frame_start_o, out, 1, one-clk pulse at frame origin
- clr_underflow_i, in, 1, clear underflow status
- underflow_o, out, 1, sticky underflow flag
- underflow_cnt_o, out, 16, saturating underflow count
- busy_o, out, 1, state != ST_IDLE

Function
REQ-003 Counters h_cnt (0..H_TOTAL-1) and v_cnt (0..V_TOTAL-1) SHALL advance only on clk edges with pix_ce_i=1; H_TOTAL=1056 and V_TOTAL=628 at the defaults.
REQ-004 h_cnt SHALL wrap to 0 after H_TOTAL-1 and increment v_cnt at that point; v_cnt SHALL wrap to 0 after V_TOTAL-1.
REQ-005 The active region SHALL be h_cnt<H_ACTIVE && v_cnt<V_ACTIVE; all other positions are blanking.
REQ-006 Sync SHALL be asserted (level SYNC_POL) for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC, and likewise vertically using the V_* parameters; otherwise sync SHALL be at ~SYNC_POL.
REQ-007 The FSM SHALL have three states:
- ST_IDLE: counters held at 0,0.
- ST_RUN: entered from ST_IDLE on a pix_ce_i cycle with enable_i=1.
- ST_STOP: entered from ST_RUN when enable_i=0; it continues scanning and returns to ST_IDLE on the ce at h=H_TOTAL-1, v=V_TOTAL-1.
- enable_i=1 in ST_STOP SHALL return the FSM to ST_RUN without a timing break.
REQ-008 pix_ready_o SHALL be combinational: pix_ce_i && state!=ST_IDLE && active region.
REQ-009 A pixel SHALL be consumed only when pix_ready_o && pix_valid_i.
REQ-010 rgb_o, hsync_o, vsync_o and de_o SHALL be registered on ce edges, giving one-ce latency, all aligned to the same (h,v).
REQ-011 On a consume, rgb_o SHALL take pix_data_i; in blanking, rgb_o SHALL be 0.
REQ-012 Underflow SHALL be defined as pix_ready_o && !pix_valid_i. On underflow:
- rgb_o <= 0 and de_o <= 1.
- underflow_o set.
- underflow_cnt_o increments, saturating at 16'hFFFF.
- no pixel is consumed.
REQ-013 clr_underflow_i SHALL clear underflow_o and underflow_cnt_o. If clear and underflow occur in the same cycle, the result SHALL be underflow_o=1 and underflow_cnt_o=1.
REQ-014 req_x_o SHALL equal h_cnt in the active region and 0 otherwise.
REQ-015 req_y_o SHALL be registered and updated on the ce with h_cnt==H_ACTIVE: v_cnt+1 if v_cnt<V_ACTIVE-1, else 0. This value is held until the next update.
REQ-016 frame_start_o SHALL pulse for one clk on the ce edge where h=0, v=0 in ST_RUN.
REQ-017 In ST_IDLE the block SHALL drive: rgb_o=0, de_o=0, syncs at ~SYNC_POL, pix_ready_o=0, busy_o=0.
REQ-018 Counter arithmetic SHALL be 11 bits unsigned; comparisons SHALL use parameter-derived constants only.

Reset
REQ-019 Asserting rst_ni low SHALL immediately put the block in ST_IDLE, even mid-frame, with the following values:
- counters 0
- rgb_o 0, de_o 0
- hsync_o/vsync_o ~SYNC_POL
- req_x_o 0, req_y_o 0
- frame_start_o 0
- underflow_o 0, underflow_cnt_o 0

Verification
REQ-020 Free-running 800x600 test, pix_ce_i=1, enable_i=1, pix_valid_i=1 with incrementing data:
- 1056 ce per line, 628 lines per frame.
- hsync high 128 ce starting at h=840.
- vsync high lines 601-604.
- de_o high 480000 ce per frame.
- rgb_o = data one ce later.
REQ-021 Underflow test: drop pix_valid_i for 3 active ce -> underflow_cnt_o=3, underflow_o=1, rgb_o=0 for those 3 slots, no pixel consumed; then pulse clr_underflow_i -> both outputs 0.
REQ-022 req_y_o test: at h=800 of line 5 -> req_y_o=6; at line 599 -> req_y_o=0; first value after reset is 0.
REQ-023 Stop test: deassert enable_i at v=100 -> scan completes through v=627, h=1055, then busy_o=0 and pix_ready_o=0; re-enable -> frame_start_o pulses at the next (0,0).
REQ-024 Gated clock-enable test: pix_ce_i=1 every 2nd clk -> all outputs and counters change only on ce edges; frame_start_o pulse width is 1 clk.
REQ-025 Reset test: rst_ni low at v=300 -> all outputs return to their REQ-019 values immediately, without waiting for a clk edge.
